dtree_seq: RTL and testbench

DTREE_SEQ -- requirements
Module: dtree_seq

---
 rtl/dtree_seq.sv | 156 +++++++++++++++
 tb/tb_dtree_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq.sv
// Sequential decision-tree inference engine: walks a register-based node table
// one node per cycle from node 0 until a leaf or the depth limit is reached.
// Node word, MSB to LSB: leaf, fidx, prec, thr, left, right.
// The leaf field is active-low (0 = leaf) so that a cleared table word is a
// leaf returning class 0.
module dtree_seq #(
  parameter int unsigned NFEAT  = 4,
  parameter int unsigned FW     = 8,
  parameter int unsigned NODES  = 64,
  parameter int unsigned CLASSW = 2,
  parameter int unsigned MAXD   = 15,
  localparam int unsigned AW    = $clog2(NODES),
  localparam int unsigned FIDXW = (NFEAT > 1) ? $clog2(NFEAT) : 1,
  localparam int unsigned PW    = $clog2(FW + 1),
  localparam int unsigned NW    = 1 + FIDXW + PW + FW + 2 * AW,
  localparam int unsigned DW    = $clog2(MAXD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NFEAT*FW-1:0]     in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CLASSW-1:0]       out_class,
  output logic                    out_err,
  output logic [DW-1:0]           out_depth,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [NW-1:0]           cfg_data
);

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e              state_q, state_d;
  logic [NFEAT*FW-1:0] x_q, x_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [CLASSW-1:0]   class_q, class_d;
  logic                err_q, err_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [NW-1:0]       tbl_q [NODES];
  logic [NW-1:0]       tbl_d [NODES];

  // Fields of the node currently addressed by the walk pointer
  logic [NW-1:0]    node;
  logic             n_leaf;
  logic [FIDXW-1:0] n_fidx;
  logic [PW-1:0]    n_prec;
  logic [FW-1:0]    n_thr;
  logic [AW-1:0]    n_left;
  logic [AW-1:0]    n_right;

  assign node    = tbl_q[ptr_q];
  assign n_leaf  = ~node[NW-1];
  assign n_fidx  = node[NW-2 -: FIDXW];
  assign n_prec  = node[NW-2-FIDXW -: PW];
  assign n_thr   = node[2*AW+FW-1 -: FW];
  assign n_left  = node[2*AW-1 -: AW];
  assign n_right = node[AW-1:0];

  logic [FW-1:0] feat;
  logic [PW-1:0] prec_eff;
  logic [FW-1:0] feat_v;
  logic          go_left;
  logic [DW-1:0] cnt_inc;

  // Feature select and precision-truncated compare; out-of-range fidx selects 0
  always_comb begin
    feat = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (n_fidx == FIDXW'(i)) feat = x_q[i*FW +: FW];
    end
    prec_eff = ((n_prec == '0) || (n_prec > PW'(FW))) ? PW'(FW) : n_prec;
    feat_v   = feat >> (PW'(FW) - prec_eff);
    go_left  = (feat_v <= n_thr);
    cnt_inc  = cnt_q + DW'(1);
  end

  // Engine FSM next-state and result registers
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    err_d   = err_q;
    depth_d = depth_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        cnt_d = cnt_inc;
        if (n_leaf) begin
          class_d = n_thr[CLASSW-1:0];
          err_d   = 1'b0;
          depth_d = cnt_inc;
          state_d = StDone;
        end else if (cnt_inc == DW'(MAXD)) begin
          class_d = '0;
          err_d   = 1'b1;
          depth_d = DW'(MAXD);
          state_d = StDone;
        end else begin
          ptr_d = go_left ? n_left : n_right;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Table writes only while idle with no pending input, so a walk never sees a changing table
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && (state_q == StIdle) && !in_valid) tbl_d[cfg_addr] = cfg_data;
  end

  // State, result and table registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
      depth_q <= '0;
      for (int i = 0; i < NODES; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      tbl_q   <= tbl_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;
  assign out_depth = depth_q;

endmodule

// File: tb/tb_dtree_seq.sv
// Scoreboard bench for dtree_seq: stimulus pushes expected results, a monitor
// pops and compares whenever a result is handed off.
module tb_dtree_seq;
  localparam int NFEAT = 4;
  localparam int FW = 8;
  localparam int NODES = 64;
  localparam int CLASSW = 2;
  localparam int MAXD = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic        out_err;
  logic [3:0]  out_depth;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [26:0] cfg_data;

  always #5 clk = ~clk;

  dtree_seq #(
    .NFEAT(NFEAT), .FW(FW), .NODES(NODES), .CLASSW(CLASSW), .MAXD(MAXD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data)
  );

  typedef struct packed {
    logic [1:0] c;
    logic       e;
    logic [3:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  // Random-tree model tables
  bit m_leaf[15];
  int m_fi[15];
  int m_pr[15];
  int m_th[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Node word builder; stored leaf bit is active-low
  function automatic logic [26:0] mk(input bit leaf, input int fidx, input int prec,
                                     input int thr, input int left, input int right);
    return {~leaf, 2'(fidx), 4'(prec), 8'(thr), 6'(left), 6'(right)};
  endfunction

  // Monitor: compare on every result handoff
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got class %0d depth %0d, required no result",
                 out_class, out_depth);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_class", 32'(out_class), 32'(mon_e.c));
        chk("out_err", 32'(out_err), 32'(mon_e.e));
        chk("out_depth", 32'(out_depth), 32'(mon_e.d));
      end
    end
  end

  task automatic cfg_write(input int addr, input logic [26:0] data);
    cfg_we = 1'b1;
    cfg_addr = 6'(addr);
    cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run(input logic [31:0] x, input logic [1:0] c, input logic e,
                     input logic [3:0] d, input int lat);
    exp_t t;
    int n;
    t.c = c; t.e = e; t.d = d;
    exp_q.push_back(t);
    chk("in_ready_before_start", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_x = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic model(input logic [31:0] x, output int cls, output int dep);
    int p;
    int v;
    p = 0; dep = 0; cls = 0;
    for (int s = 0; s < MAXD; s++) begin
      dep++;
      if (m_leaf[p]) begin
        cls = m_th[p] & 3;
        return;
      end
      v = int'((x >> (m_fi[p] * 8)) & 32'hFF);
      v = v >> (8 - m_pr[p]);
      p = (v <= m_th[p]) ? 2 * p + 1 : 2 * p + 2;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int cls;
    int dep;
    logic [31:0] x;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_depth", 32'(out_depth), 32'd0);

    // Cleared table: node 0 is a class-0 leaf
    run(32'hDEADBEEF, 2'd0, 1'b0, 4'd1, 1);

    // Two-level tree on feature 0 with 2-bit precision
    cfg_write(0, mk(0, 0, 2, 0, 1, 2));
    cfg_write(1, mk(1, 0, 0, 1, 0, 0));
    cfg_write(2, mk(1, 0, 0, 2, 0, 0));
    run(32'h0000003F, 2'd1, 1'b0, 4'd2, 2);
    run(32'h00000040, 2'd2, 1'b0, 4'd2, 2);
    run(32'hFFFFFF3F, 2'd1, 1'b0, 4'd2, 2);

    // Precision 0, FW and >FW all compare the full feature
    cfg_write(0, mk(0, 0, 0, 8'h80, 1, 2));
    run(32'h00000080, 2'd1, 1'b0, 4'd2, 2);
    run(32'h00000081, 2'd2, 1'b0, 4'd2, 2);
    cfg_write(0, mk(0, 0, 9, 8'h80, 1, 2));
    run(32'h00000081, 2'd2, 1'b0, 4'd2, 2);
    cfg_write(0, mk(0, 0, 8, 8'h80, 1, 2));
    run(32'h00000080, 2'd1, 1'b0, 4'd2, 2);

    // Highest feature index
    cfg_write(0, mk(0, 3, 4, 5, 1, 2));
    run(32'h5FFFFFFF, 2'd1, 1'b0, 4'd2, 2);
    run(32'h60000000, 2'd2, 1'b0, 4'd2, 2);

    // Depth overrun; a config write during the walk must be dropped
    cfg_write(0, mk(0, 0, 0, 0, 0, 0));
    fork
      run(32'h12345678, 2'd0, 1'b1, 4'd15, 15);
      begin
        repeat (4) @(posedge clk);
        #1 cfg_write(1, mk(1, 0, 0, 3, 0, 0));
      end
    join
    cfg_write(0, mk(0, 0, 2, 0, 1, 2));
    run(32'h00000000, 2'd1, 1'b0, 4'd2, 2);

    // Hold result with out_ready low while in_valid is offered
    out_ready = 1'b0;
    run(32'h00000040, 2'd2, 1'b0, 4'd2, 2);
    in_valid = 1'b1;
    in_x = 32'h0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_class", 32'(out_class), 32'd2);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("no_accept_on_release", 32'(in_ready), 32'd1);

    // Random four-level trees against the model
    for (int i = 0; i < 15; i++) begin
      m_leaf[i] = (i >= 7) ? 1'b1 : (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      m_fi[i] = $urandom_range(0, 3);
      m_pr[i] = $urandom_range(2, 5);
      m_th[i] = m_leaf[i] ? $urandom_range(0, 255) : $urandom_range(0, (1 << m_pr[i]) - 1);
      cfg_write(i, mk(m_leaf[i], m_fi[i], m_pr[i], m_th[i], 2 * i + 1, 2 * i + 2));
    end
    for (int v = 0; v < 300; v++) begin
      x = $urandom;
      model(x, cls, dep);
      run(x, 2'(cls), 1'b0, 4'(dep), dep);
    end

    // Reset mid-walk abandons the inference and clears the table
    cfg_write(0, mk(0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    in_x = 32'hA5A5A5A5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post_rst_no_result", 32'(seen), 32'd0);
    run(32'h00000040, 2'd0, 1'b0, 4'd1, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
